sw_rst_gen: RTL and testbench

Software/lock-loss reset pulse generator that produces the `i_sw_rst` input of `clk_n_rst`. It runs on the APB clock. It accepts a keyed reset request from the register block, or an optional PLL-lock-loss event, and emits a stretched, rate-limited reset pulse. `clk_n_rst` resynchronises that pulse into the PCS calibration clock domain to reset the Ethernet PCS. The block also reports busy status, a saturating event count and the cause of the last reset.

---
 rtl/sw_rst_gen.sv | 173 +++++++++++++++++
 tb/tb_sw_rst_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_rst_gen.sv
// sw_rst_gen: keyed software / PLL-lock-loss reset pulse generator.
// Runs on the APB clock and drives the i_sw_rst input of clk_n_rst with a
// stretched pulse followed by a holdoff window during which new requests
// are refused. Also reports busy status, a saturating issue count and the
// cause of the most recent reset. Every output comes straight from a flop.
module sw_rst_gen #(
  parameter int          PULSE_CYCLES   = 64,
  parameter int          HOLDOFF_CYCLES = 256,
  parameter logic [31:0] RST_KEY        = 32'h5253_5431
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_key,
  input  logic        i_lock,
  input  logic        i_lock_rst_en,
  output logic        o_req_ack,
  output logic        o_req_err,
  output logic        o_sw_rst,
  output logic        o_busy,
  output logic [7:0]  o_rst_cnt,
  output logic [1:0]  o_last_cause
);

  // One down-counter serves both the pulse and the holdoff phase, so it is
  // sized for whichever of the two is longer.
  localparam int MAX_CYCLES = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam bit               HAS_HOLDOFF = (HOLDOFF_CYCLES > 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = HAS_HOLDOFF ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

  localparam logic [7:0] CNT_SAT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             lock_q;

  logic             is_idle;
  logic             key_ok;
  logic             sw_trig;
  logic             lock_trig;
  logic             any_trig;

  logic             sw_rst_next;
  logic             busy_next;
  logic             req_ack_next;
  logic             req_err_next;
  logic [7:0]       rst_cnt_next;
  logic [1:0]       last_cause_next;

  // Triggers are only honoured in IDLE; a lock drop seen while busy is
  // simply dropped rather than queued up for later.
  assign is_idle   = (state == ST_IDLE);
  assign key_ok    = (i_req_key == RST_KEY);
  assign sw_trig   = i_req_valid && key_ok && is_idle;
  assign lock_trig = lock_q && !i_lock && i_lock_rst_en && is_idle;
  assign any_trig  = sw_trig || lock_trig;

  // Previous lock level for falling-edge detection; cleared on reset so a
  // lock loss only counts after lock has been seen high again.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= i_lock;
    end
  end

  // State register and shared phase counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: IDLE -> ASSERT on a trigger, ASSERT -> HOLDOFF (or
  // straight back to IDLE when there is no holdoff), HOLDOFF -> IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (any_trig) begin
          state_next = ST_ASSERT;
          cnt_next   = PULSE_LOAD;
        end
      end
      ST_ASSERT: begin
        if (cnt == '0) begin
          if (HAS_HOLDOFF) begin
            state_next = ST_HOLDOFF;
            cnt_next   = HOLD_LOAD;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      ST_HOLDOFF: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic: computes the next value of every output flop from the
  // upcoming state and this cycle's triggers, so outputs stay registered.
  always_comb begin
    sw_rst_next     = (state_next == ST_ASSERT);
    busy_next       = (state_next != ST_IDLE);
    req_ack_next    = sw_trig;
    req_err_next    = i_req_valid && !sw_trig;
    rst_cnt_next    = o_rst_cnt;
    last_cause_next = o_last_cause;
    if (any_trig) begin
      last_cause_next = {lock_trig, sw_trig};
      if (o_rst_cnt != CNT_SAT) begin
        rst_cnt_next = o_rst_cnt + 8'd1;
      end
    end
  end

  // Output registers; reset aborts any pulse in progress immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sw_rst     <= 1'b0;
      o_busy       <= 1'b0;
      o_req_ack    <= 1'b0;
      o_req_err    <= 1'b0;
      o_rst_cnt    <= 8'd0;
      o_last_cause <= 2'b00;
    end else begin
      o_sw_rst     <= sw_rst_next;
      o_busy       <= busy_next;
      o_req_ack    <= req_ack_next;
      o_req_err    <= req_err_next;
      o_rst_cnt    <= rst_cnt_next;
      o_last_cause <= last_cause_next;
    end
  end

`ifndef SYNTHESIS
  // The pulse always sits inside the busy window, and a request is never
  // both accepted and refused.
  a_pulse_within_busy: assert property (@(posedge i_clk) disable iff (i_rst) o_sw_rst |-> o_busy);
  a_ack_err_exclusive: assert property (@(posedge i_clk) disable iff (i_rst) !(o_req_ack && o_req_err));
`endif

endmodule

// File: tb/tb_sw_rst_gen.sv
// tb_sw_rst_gen: randomized and directed bench for sw_rst_gen with a
// cycle-indexed reference model and an ack/err event scoreboard.
module tb_sw_rst_gen;

  // Shortened pulse/holdoff keep the 300-request saturation run small.
  localparam int          P    = 16;
  localparam int          H    = 32;
  localparam logic [31:0] KEY  = 32'h5253_5431;
  localparam int          MAXC = 24000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_key = 32'h0;
  logic        lock = 1'b0;
  logic        lock_en = 1'b0;
  logic        req_ack;
  logic        req_err;
  logic        sw_rst;
  logic        busy;
  logic [7:0]  rst_cnt;
  logic [1:0]  last_cause;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: absolute cycle numbers of the last pulse / busy cycle.
  int         m_pulse_end = -1;
  int         m_busy_end  = -1;
  int         m_count     = 0;
  logic [1:0] m_cause     = 2'b00;
  logic       m_lock_prev = 1'b0;

  // Expected register outputs, indexed by the cycle in which they show.
  bit         exp_valid [MAXC];
  logic       exp_sw    [MAXC];
  logic       exp_busy  [MAXC];
  logic [7:0] exp_cnt   [MAXC];
  logic [1:0] exp_cause [MAXC];

  typedef struct {
    int cyc;
    bit is_ack;
  } ev_t;
  ev_t evq[$];

  logic cur_lock = 1'b1;
  logic cur_en   = 1'b1;

  sw_rst_gen #(
    .PULSE_CYCLES  (P),
    .HOLDOFF_CYCLES(H),
    .RST_KEY       (KEY)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_key    (req_key),
    .i_lock       (lock),
    .i_lock_rst_en(lock_en),
    .o_req_ack    (req_ack),
    .o_req_err    (req_err),
    .o_sw_rst     (sw_rst),
    .o_busy       (busy),
    .o_rst_cnt    (rst_cnt),
    .o_last_cause (last_cause)
  );

  // Free-running clock and a cycle counter that advances on each rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model for one cycle n: decides acceptance from the busy window
  // arithmetic, queues the ack/err event, and records what cycle n+1 must show.
  task automatic modelStep(input int n, input logic r, input logic v, input logic [31:0] k,
                           input logic lk_in, input logic en);
    bit idle;
    bit sw;
    bit lk;
    int nx;
    if (r) begin
      m_count     = 0;
      m_cause     = 2'b00;
      m_pulse_end = n;
      m_busy_end  = n;
      m_lock_prev = 1'b0;
    end else begin
      idle = (n > m_busy_end);
      sw   = v && (k == KEY) && idle;
      lk   = m_lock_prev && !lk_in && en && idle;
      if (v) evq.push_back('{n + 1, sw});
      if (sw || lk) begin
        if (m_count < 255) m_count++;
        m_cause     = {lk, sw};
        m_pulse_end = n + P;
        m_busy_end  = n + P + H;
      end
      m_lock_prev = lk_in;
    end
    nx = n + 1;
    if (nx < MAXC) begin
      exp_valid[nx] = 1'b1;
      exp_sw[nx]    = (nx <= m_pulse_end);
      exp_busy[nx]  = (nx <= m_busy_end);
      exp_cnt[nx]   = 8'(m_count);
      exp_cause[nx] = m_cause;
    end
  endtask

  // Drives one cycle of inputs just after the rising edge and runs the model.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] k,
                               input logic lk_in, input logic en);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_key   = k;
    lock      = lk_in;
    lock_en   = en;
    modelStep(cyc, r, v, k, lk_in, en);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, cur_lock, cur_en);
  endtask

  task automatic request(input logic [31:0] k);
    applyStimulus(1'b0, 1'b1, k, cur_lock, cur_en);
  endtask

  // Monitor side: compares register outputs every cycle and pops the event
  // queue whenever the DUT shows an ack or err pulse (or one was due).
  task automatic checkOutput();
    bit   due;
    logic e_ack;
    logic e_err;
    if (cyc >= MAXC || !exp_valid[cyc]) return;
    checks++;
    if ({sw_rst, busy, rst_cnt, last_cause} !== {exp_sw[cyc], exp_busy[cyc], exp_cnt[cyc], exp_cause[cyc]}) begin
      errors++;
      $display("[TB] FAIL outputs cyc=%0d sw_rst/busy/cnt/cause got %b/%b/%0d/%b want %b/%b/%0d/%b",
               cyc, sw_rst, busy, rst_cnt, last_cause,
               exp_sw[cyc], exp_busy[cyc], exp_cnt[cyc], exp_cause[cyc]);
    end
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL stale_event cyc=%0d got none want event from cyc %0d", cyc, evq[0].cyc);
      void'(evq.pop_front());
    end
    due = (evq.size() > 0) && (evq[0].cyc == cyc);
    if (due || req_ack || req_err) begin
      e_ack = due && evq[0].is_ack;
      e_err = due && !evq[0].is_ack;
      checks++;
      if (req_ack !== e_ack || req_err !== e_err) begin
        errors++;
        $display("[TB] FAIL ack_err cyc=%0d got ack=%b err=%b want ack=%b err=%b",
                 cyc, req_ack, req_err, e_ack, e_err);
      end
      if (due) void'(evq.pop_front());
    end
  endtask

  // Sample everything on the falling edge, well away from the active edge.
  always @(negedge clk) checkOutput();

  // Directed scenarios, a random phase, then the saturation run.
  initial begin
    logic        r_rst;
    logic        r_v;
    logic [31:0] r_k;

    cur_lock = 1'b1;
    cur_en   = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, cur_lock, cur_en);
    idleCycles(4);

    $display("[TB] good key, busy rejections and earliest re-trigger");
    request(KEY);
    idleCycles(P / 2 - 1);
    request(KEY);
    idleCycles(P + H / 2 - P / 2 - 1);
    request(KEY);
    idleCycles(H / 2 - 1);
    request(KEY);
    request(KEY);
    idleCycles(P + H);

    $display("[TB] bad keys in idle");
    request(32'h0);
    idleCycles(2);
    request(KEY ^ 32'h1);
    idleCycles(2);
    request(KEY ^ 32'h8000_0000);
    idleCycles(3);

    $display("[TB] lock loss enabled, disabled and simultaneous with request");
    cur_lock = 1'b0;
    idleCycles(1);
    idleCycles(P + H);
    cur_lock = 1'b1;
    idleCycles(2);
    cur_en   = 1'b0;
    cur_lock = 1'b0;
    idleCycles(3);
    cur_lock = 1'b1;
    idleCycles(2);
    cur_en   = 1'b1;
    cur_lock = 1'b0;
    request(KEY);
    idleCycles(P + H);

    $display("[TB] reset in the middle of a pulse and lock after reset");
    cur_lock = 1'b1;
    idleCycles(2);
    request(KEY);
    idleCycles(9);
    applyStimulus(1'b1, 1'b0, 32'h0, cur_lock, cur_en);
    cur_lock = 1'b0;
    idleCycles(3);
    cur_lock = 1'b1;
    idleCycles(1);
    cur_lock = 1'b0;
    idleCycles(P + H + 2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      r_rst = ($urandom_range(0, 399) == 0);
      r_v   = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0, 1:    r_k = KEY;
        2:       r_k = $urandom;
        default: r_k = KEY ^ (32'h1 << $urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 11) == 0) cur_lock = ~cur_lock;
      if ($urandom_range(0, 49) == 0) cur_en = ~cur_en;
      applyStimulus(r_rst, r_v, r_k, cur_lock, cur_en);
    end

    $display("[TB] counter saturation");
    cur_lock = 1'b1;
    cur_en   = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, cur_lock, cur_en);
    for (int i = 0; i < 300; i++) begin
      request(KEY);
      idleCycles(P + H);
    end
    idleCycles(2);

    @(negedge clk);
    #1;
    checks++;
    if (rst_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL saturation got %0d want 255", rst_cnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_events got %0d want 0", evq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
